// File: rtl/io_peer.sv
// ---------------------------------------------------------------------------
// io_peer
//   Byte-wide mailbox between a processor using a four-phase handshake and a
//   host using FIFO-style push/pop strobes.
//     TX FIFO : host -> processor (host pushes, processor read pops)
//     RX FIFO : processor -> host (processor write pushes, host pops)
//
// Ports
//   g_clk, g_clr     clock (rising edge) / asynchronous active-low reset
//   hs_out, rd_wr    processor request strobe and direction (1 = read)
//   bus_out          processor write data
//   hs_in            acknowledge to the processor (registered)
//   bus_in           registered read data, holds until the next read
//   ext_int          registered data-available interrupt
//   tx_wr, tx_data   host push into TX; tx_full / tx_count status
//   rx_rd, rx_data   host pop from RX (rx_data is show-ahead head);
//                    rx_empty / rx_count status
//   dbg_state        current handshake state (0 = IDLE, 1 = ACK)
//
// Processor handshake (valid/ready contract):
//   The processor raises hs_out with rd_wr (and bus_out for writes) stable.
//   The block accepts in IDLE only when the FIFO can serve the request
//   (RX not full for a write, TX not empty for a read), transfers exactly
//   one byte on that edge and raises hs_in. hs_in then holds until hs_out
//   is sampled low; rd_wr/bus_out are ignored meanwhile.
// ---------------------------------------------------------------------------
module io_peer #(
    parameter int DEPTH = 4
) (
    input  logic                   g_clk,
    input  logic                   g_clr,
    input  logic                   hs_out,
    input  logic [7:0]             bus_out,
    input  logic                   rd_wr,
    output logic                   hs_in,
    output logic [7:0]             bus_in,
    output logic                   ext_int,
    input  logic                   tx_wr,
    input  logic [7:0]             tx_data,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_count,
    input  logic                   rx_rd,
    output logic [7:0]             rx_data,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            hs_in_q, hs_in_d;
    logic [7:0]      bus_in_q, bus_in_d;
    logic            ext_int_q, ext_int_d;

    logic [7:0]      tx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0]   tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW:0]     tx_count_q, tx_count_d;

    logic [7:0]      rx_mem [DEPTH];
    logic [AW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0]   rx_rd_ptr_q, rx_rd_ptr_d;
    logic [AW:0]     rx_count_q, rx_count_d;

    logic            tx_push, tx_pop, rx_push, rx_pop;

    always_comb begin
        state_d  = state_q;
        hs_in_d  = hs_in_q;
        bus_in_d = bus_in_q;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hs_out) begin
                    if (rd_wr) begin
                        if (tx_count_q != '0) begin
                            tx_pop   = 1'b1;
                            bus_in_d = tx_mem[tx_rd_ptr_q];
                            hs_in_d  = 1'b1;
                            state_d  = ST_ACK;
                        end
                    end else if (rx_count_q != CNT_FULL) begin
                        rx_push = 1'b1;
                        hs_in_d = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (!hs_out) begin
                    hs_in_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hs_in_d = 1'b0;
            end
        endcase

        // A full TX FIFO still accepts a push when the processor pops it on
        // the same edge. RX pushes are gated by the processor side above.
        tx_push = tx_wr && ((tx_count_q != CNT_FULL) || tx_pop);
        rx_pop  = rx_rd && (rx_count_q != '0);

        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;

        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase

        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase

        // Interrupt reflects the TX count seen on the previous edge and is
        // held low for every cycle the handshake sits in ACK.
        ext_int_d = (tx_count_q != '0) && (state_d == ST_IDLE);
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q     <= ST_IDLE;
            hs_in_q     <= 1'b0;
            bus_in_q    <= 8'h00;
            ext_int_q   <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            hs_in_q     <= hs_in_d;
            bus_in_q    <= bus_in_d;
            ext_int_q   <= ext_int_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // Storage arrays are not reset; only the pointers define validity.
    always_ff @(posedge g_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= tx_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= bus_out;
        end
    end

    assign hs_in     = hs_in_q;
    assign bus_in    = bus_in_q;
    assign ext_int   = ext_int_q;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
    assign tx_full   = (tx_count_q == CNT_FULL);
    assign rx_empty  = (rx_count_q == '0);
    assign rx_data   = rx_mem[rx_rd_ptr_q];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_io_peer.sv
module tb_io_peer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       g_clr;
    logic       hs_out;
    logic [7:0] bus_out;
    logic       rd_wr;
    logic       hs_in;
    logic [7:0] bus_in;
    logic       ext_int;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic [2:0] tx_count;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       dbg_state;

    int checks   = 0;
    int failures = 0;

    io_peer #(.DEPTH(DEPTH)) dut (
        .g_clk    (clk),
        .g_clr    (g_clr),
        .hs_out   (hs_out),
        .bus_out  (bus_out),
        .rd_wr    (rd_wr),
        .hs_in    (hs_in),
        .bus_in   (bus_in),
        .ext_int  (ext_int),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .rx_rd    (rx_rd),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_count (rx_count),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Transaction-level view: two byte queues plus the handshake phase.
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    bit         m_busy;
    logic [7:0] m_bus_in;
    bit         m_ext;
    bit         mdl_on = 0;

    function automatic void model_reset();
        m_tx.delete();
        m_rx.delete();
        m_busy   = 0;
        m_bus_in = 8'h00;
        m_ext    = 0;
    endfunction

    // Applies the current inputs as one clock edge.
    function automatic void model_step();
        bit       served_read  = 0;
        bit       served_write = 0;
        bit       next_busy    = m_busy;
        int       tx_before    = m_tx.size();
        if (!m_busy && hs_out) begin
            if (rd_wr && m_tx.size() > 0)          served_read  = 1;
            if (!rd_wr && m_rx.size() < DEPTH)     served_write = 1;
            next_busy = served_read || served_write;
        end else if (m_busy && !hs_out) begin
            next_busy = 0;
        end
        if (served_read) m_bus_in = m_tx.pop_front();
        if (tx_wr && m_tx.size() < DEPTH) m_tx.push_back(tx_data);
        if (rx_rd && m_rx.size() > 0) void'(m_rx.pop_front());
        if (served_write) m_rx.push_back(bus_out);
        m_ext  = (tx_before != 0) && !next_busy;
        m_busy = next_busy;
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        chk("mdl_hs_in",   32'(hs_in),    32'(m_busy));
        chk("mdl_bus_in",  32'(bus_in),   32'(m_bus_in));
        chk("mdl_ext_int", 32'(ext_int),  32'(m_ext));
        chk("mdl_tx_cnt",  32'(tx_count), 32'(m_tx.size()));
        chk("mdl_rx_cnt",  32'(rx_count), 32'(m_rx.size()));
        chk("mdl_tx_full", 32'(tx_full),  32'(m_tx.size() == DEPTH));
        chk("mdl_rx_empty",32'(rx_empty), 32'(m_rx.size() == 0));
        if (m_rx.size() > 0) chk("mdl_rx_data", 32'(rx_data), 32'(m_rx[0]));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (mdl_on) check_model();
    endtask

    task automatic idle_inputs();
        hs_out  = 1'b0;
        rd_wr   = 1'b0;
        bus_out = 8'h00;
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        rx_rd   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        g_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        g_clr = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       hs_out;
        logic       rd_wr;
        logic [7:0] bus_out;
        logic       tx_wr;
        logic [7:0] tx_data;
        logic       rx_rd;
        logic       e_hs_in;
        logic [7:0] e_bus_in;
        logic       e_ext;
        logic [2:0] e_tx;
        logic [2:0] e_rx;
        logic [7:0] e_rxd;
    } vec_t;

    vec_t tbl[10];
    logic [7:0] expv;

    initial begin
        g_clr = 1'b0;
        idle_inputs();
        model_reset();

        // write A5, host pushes 3C/7E, two processor reads, host pops
        tbl[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 3'd1, 8'hA5};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 8'hA5};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 3'd1, 8'hA5};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 3'd1, 8'hA5};
        tbl[4] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 3'd1, 3'd1, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 3'd1, 3'd1, 8'hA5};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 3'd1, 3'd1, 8'hA5};
        tbl[7] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b0, 3'd0, 3'd1, 8'hA5};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7E, 1'b0, 3'd0, 3'd1, 8'hA5};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7E, 1'b0, 3'd0, 3'd0, 8'h00};

        // ---- reset state ----
        #3;
        chk("rst_hs_in",    32'(hs_in),    32'd0);
        chk("rst_bus_in",   32'(bus_in),   32'h00);
        chk("rst_ext_int",  32'(ext_int),  32'd0);
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_tx_full",  32'(tx_full),  32'd0);
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("rst_state",    32'(dbg_state),32'd0);
        @(posedge clk);
        #1;
        g_clr = 1'b1;

        // ---- table-driven basic transfers ----
        for (int i = 0; i < 10; i++) begin
            hs_out  = tbl[i].hs_out;
            rd_wr   = tbl[i].rd_wr;
            bus_out = tbl[i].bus_out;
            tx_wr   = tbl[i].tx_wr;
            tx_data = tbl[i].tx_data;
            rx_rd   = tbl[i].rx_rd;
            tick();
            chk($sformatf("tbl%0d_hs_in", i),   32'(hs_in),    32'(tbl[i].e_hs_in));
            chk($sformatf("tbl%0d_bus_in", i),  32'(bus_in),   32'(tbl[i].e_bus_in));
            chk($sformatf("tbl%0d_ext_int", i), 32'(ext_int),  32'(tbl[i].e_ext));
            chk($sformatf("tbl%0d_tx_count", i),32'(tx_count), 32'(tbl[i].e_tx));
            chk($sformatf("tbl%0d_rx_count", i),32'(rx_count), 32'(tbl[i].e_rx));
            if (tbl[i].e_rx != 3'd0)
                chk($sformatf("tbl%0d_rx_data", i), 32'(rx_data), 32'(tbl[i].e_rxd));
        end
        idle_inputs();

        // ---- stall on full RX ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            hs_out = 1'b1; rd_wr = 1'b0; bus_out = 8'(8'h20 + i);
            tick();
            chk("full_fill_ack", 32'(hs_in), 32'd1);
            hs_out = 1'b0;
            tick();
        end
        chk("full_rx_count", 32'(rx_count), 32'(DEPTH));
        hs_out = 1'b1; rd_wr = 1'b0; bus_out = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_stall_hs_in", 32'(hs_in), 32'd0);
        end
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        chk("full_pop_hs_in",    32'(hs_in),    32'd0);
        chk("full_pop_rx_count", 32'(rx_count), 32'(DEPTH - 1));
        tick();
        chk("full_resume_hs_in", 32'(hs_in),    32'd1);
        chk("full_resume_rx_cnt",32'(rx_count), 32'(DEPTH));
        chk("full_resume_head",  32'(rx_data),  32'h21);
        hs_out = 1'b0;
        tick();
        chk("full_release_hs_in", 32'(hs_in), 32'd0);

        // ---- read on empty TX ----
        do_reset();
        tx_wr = 1'b1; tx_data = 8'h99;
        tick();
        tx_wr = 1'b0;
        hs_out = 1'b1; rd_wr = 1'b1;
        tick();
        chk("empty_pre_bus_in", 32'(bus_in), 32'h99);
        hs_out = 1'b0;
        tick();
        hs_out = 1'b1; rd_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_stall_hs_in",  32'(hs_in),  32'd0);
            chk("empty_stall_bus_in", 32'(bus_in), 32'h99);
        end
        tx_wr = 1'b1; tx_data = 8'h11;
        tick();
        tx_wr = 1'b0;
        chk("empty_push_hs_in", 32'(hs_in), 32'd0);
        tick();
        chk("empty_serve_hs_in",  32'(hs_in),    32'd1);
        chk("empty_serve_bus_in", 32'(bus_in),   32'h11);
        chk("empty_serve_tx_cnt", 32'(tx_count), 32'd0);
        hs_out = 1'b0;
        tick();

        // ---- simultaneous push/pop with wrap-around ----
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            tx_wr = 1'b1; tx_data = 8'(8'h40 + i);
            exp_q.push_back(tx_data);
            tick();
        end
        tx_wr = 1'b0;
        chk("sim_start_tx_count", 32'(tx_count), 32'd2);
        for (int k = 0; k < 11; k++) begin
            hs_out = 1'b1; rd_wr = 1'b1;
            tx_wr = 1'b1; tx_data = 8'(8'h50 + k);
            expv = exp_q.pop_front();
            exp_q.push_back(tx_data);
            tick();
            chk("sim_tx_count", 32'(tx_count), 32'd2);
            chk("sim_bus_in",   32'(bus_in),   32'(expv));
            hs_out = 1'b0; tx_wr = 1'b0;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            tx_wr = 1'b1; tx_data = 8'(8'h70 + i);
            exp_q.push_back(tx_data);
            tick();
        end
        chk("sim_full_flag", 32'(tx_full), 32'd1);
        tx_data = 8'h72;
        tick();
        chk("sim_full_ignored", 32'(tx_count), 32'(DEPTH));
        hs_out = 1'b1; rd_wr = 1'b1; tx_data = 8'h73;
        expv = exp_q.pop_front();
        exp_q.push_back(tx_data);
        tick();
        chk("sim_full_pushpop_cnt", 32'(tx_count), 32'(DEPTH));
        chk("sim_full_pushpop_bus", 32'(bus_in),   32'(expv));
        hs_out = 1'b0; tx_wr = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            hs_out = 1'b1; rd_wr = 1'b1;
            expv = exp_q.pop_front();
            tick();
            chk("sim_drain_bus_in", 32'(bus_in), 32'(expv));
            hs_out = 1'b0;
            tick();
        end
        chk("sim_drain_tx_count", 32'(tx_count), 32'd0);

        // ---- reset in the middle of a handshake ----
        do_reset();
        tx_wr = 1'b1; tx_data = 8'h9A;
        tick();
        tx_data = 8'h9B;
        tick();
        tx_wr = 1'b0;
        hs_out = 1'b1; rd_wr = 1'b0; bus_out = 8'h33;
        tick();
        hs_out = 1'b0;
        tick();
        hs_out = 1'b1; rd_wr = 1'b1;
        tick();
        chk("mid_pre_hs_in",  32'(hs_in),  32'd1);
        chk("mid_pre_bus_in", 32'(bus_in), 32'h9A);
        #2;
        g_clr = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_hs_in",    32'(hs_in),    32'd0);
        chk("mid_rst_bus_in",   32'(bus_in),   32'h00);
        chk("mid_rst_tx_count", 32'(tx_count), 32'd0);
        chk("mid_rst_rx_count", 32'(rx_count), 32'd0);
        chk("mid_rst_ext_int",  32'(ext_int),  32'd0);
        chk("mid_rst_state",    32'(dbg_state),32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        g_clr = 1'b1;
        hs_out = 1'b1; rd_wr = 1'b0; bus_out = 8'h44;
        tick();
        chk("mid_after_hs_in",    32'(hs_in),    32'd1);
        chk("mid_after_rx_count", 32'(rx_count), 32'd1);
        chk("mid_after_rx_data",  32'(rx_data),  32'h44);
        hs_out = 1'b0;
        tick();
        chk("mid_after_release", 32'(hs_in), 32'd0);

        // ---- randomized traffic against the reference model ----
        do_reset();
        mdl_on = 1;
        for (int n = 0; n < 600; n++) begin
            hs_out  = 1'($urandom_range(0, 1));
            rd_wr   = 1'($urandom_range(0, 1));
            bus_out = 8'($urandom_range(0, 255));
            tx_wr   = ($urandom_range(0, 99) < 45);
            tx_data = 8'($urandom_range(0, 255));
            rx_rd   = ($urandom_range(0, 99) < 35);
            tick();
        end
        mdl_on = 0;
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_peer.md
IO_PEER -- requirements
Module: io_peer

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, the entry count of each FIFO (a power of two, minimum 2).
- REQ-002 SHALL have port g_clk, input, 1 bit, the single clock; all state changes on the rising edge.
- REQ-003 SHALL have port g_clr, input, 1 bit, an asynchronous active-low reset.
- REQ-004 SHALL have port hs_out, input, 1 bit, the processor request strobe.
- REQ-005 SHALL have port bus_out, input, 8 bits, processor write data, valid while hs_out=1.
- REQ-006 SHALL have port rd_wr, input, 1 bit, transfer direction valid while hs_out=1: 1 means the processor reads, 0 means the processor writes.
- REQ-007 SHALL have port hs_in, output, 1 bit, the acknowledge to the processor.
- REQ-008 SHALL have port bus_in, output, 8 bits, read data to the processor.
- REQ-009 SHALL have port ext_int, output, 1 bit, the data-available interrupt.
- REQ-010 SHALL have the following host-side ports:
  - tx_wr, input, 1 bit, push request;
  - tx_data, input, 8 bits, push data;
  - tx_full, output, 1 bit;
  - tx_count, output, log2(DEPTH)+1 bits.
- REQ-011 SHALL have the following further host-side ports:
  - rx_rd, input, 1 bit, pop request;
  - rx_data, output, 8 bits;
  - rx_empty, output, 1 bit;
  - rx_count, output, log2(DEPTH)+1 bits.

Function
- REQ-012 SHALL contain a TX FIFO (host to processor) and an RX FIFO (processor to host), each DEPTH×8 bits, using circular pointers that wrap modulo DEPTH.
- REQ-013 SHALL implement a four-phase handshake with states IDLE and ACK.
- REQ-014 In IDLE, on an edge with hs_out=1 and rd_wr=0, SHALL do the following when the RX FIFO is not full:
  - push bus_out into the RX FIFO;
  - set hs_in=1;
  - go to ACK.
  If the RX FIFO is full, it SHALL remain in IDLE with hs_in=0, stalling the processor.
- REQ-015 In IDLE, on an edge with hs_out=1 and rd_wr=1, SHALL do the following when the TX FIFO is not empty:
  - register the TX head into bus_in;
  - pop the TX FIFO;
  - set hs_in=1;
  - go to ACK.
  If the TX FIFO is empty, it SHALL remain in IDLE with hs_in=0.
- REQ-016 In ACK, SHALL hold hs_in=1 until hs_out is sampled 0; on that edge it SHALL clear hs_in and return to IDLE.
- REQ-017 SHALL ignore rd_wr and bus_out changes while in ACK; exactly one transfer occurs per request.
- REQ-018 Latency: hs_in SHALL rise one edge after hs_out is first sampled high with the FIFO condition met, and SHALL fall one edge after hs_out is sampled low.
- REQ-019 bus_in SHALL be registered and SHALL hold its last read value until the next read transfer.
- REQ-020 rx_data SHALL be the combinational (show-ahead) head of the RX FIFO; rx_rd pops it on the edge.
- REQ-021 A push to a full FIFO and a pop from an empty FIFO SHALL be ignored, with no change to pointers or counts.
- REQ-022 A simultaneous host push and processor pop on the TX FIFO SHALL both take effect, leaving tx_count unchanged; the same SHALL hold for a processor push and host pop on the RX FIFO.
- REQ-023 On a TX push to a FIFO that is simultaneously being popped while full, SHALL accept the push.
- REQ-024 tx_full/rx_empty SHALL be derived from the counts: tx_full=(tx_count==DEPTH), rx_empty=(rx_count==0).
- REQ-025 ext_int SHALL be registered, equal to (tx_count≠0) as of the previous edge, and forced to 0 while in ACK.

Reset
- REQ-026 While g_clr=0, the block SHALL immediately (asynchronously) set:
  - state=IDLE;
  - hs_in=0, bus_in=8'h00, ext_int=0;
  - all FIFO pointers and counts to 0, so tx_full=0 and rx_empty=1.
- REQ-027 A reset asserted mid-handshake SHALL abort the transfer; a byte already pushed or popped on the prior edge SHALL be discarded with the FIFO clear.
- REQ-028 After g_clr rises, the block SHALL first respond to hs_out on the following edge; FIFO memory contents need not be cleared.

Verification
- REQ-029 Processor write: with RX empty, drive bus_out=8'hA5, rd_wr=0, hs_out=1. Required:
  - hs_in=1 after one edge, rx_count=1, rx_data=8'hA5;
  - after hs_out is dropped, hs_in=0 after one edge.
- REQ-030 Processor read: host pushes 8'h3C and then 8'h7E, and ext_int=1 the edge after the first push. Required:
  - the first read gives bus_in=8'h3C, the second gives 8'h7E, in order;
  - tx_count returns to 0 and ext_int=0.
- REQ-031 Stall on full: push DEPTH write transfers, then issue a fifth hs_out with rd_wr=0. Required:
  - hs_in stays 0;
  - a single host rx_rd lets hs_in rise on the next edge, with rx_count=DEPTH.
- REQ-032 Read on empty: hs_out=1, rd_wr=1 with TX empty. Required:
  - hs_in stays 0 and bus_in keeps its old value;
  - a host push of 8'h11 causes hs_in=1 one edge later with bus_in=8'h11.
- REQ-033 Simultaneous events: with tx_count=2, apply tx_wr on the same edge the processor read is accepted. Required:
  - tx_count stays 2;
  - wrap-around order is preserved over 10 further push/pop pairs.
- REQ-034 Reset mid-handshake: pull g_clr low while in ACK. Required:
  - hs_in=0, bus_in=8'h00, counts=0 without waiting for a clock edge;
  - a normal transfer succeeds after release.
